// File: rtl/sprite_pkg.sv
// Shared definitions for the Batman sprite fetch block: default geometry of
// the jump sprite sheet, the animation FSM state type and the transparent key.
package sprite_pkg;

  localparam int unsigned SprWDefault      = 64;  // sprite width, power of two
  localparam int unsigned SprHDefault      = 64;  // sprite height
  localparam int unsigned FramesDefault    = 4;   // frames stored back to back
  localparam int unsigned FrameHoldDefault = 6;   // frame_start pulses per frame

  typedef enum logic [0:0] {
    IDLE,
    PLAY
  } anim_state_t;

  // Palette index 0 is the colour key; it never counts as an opaque pixel.
  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Jump animation sequencer. Starts on jump_trig_i from IDLE, then steps the
// displayed sheet frame once every FRAME_HOLD frame_start pulses, returning
// to IDLE after the last frame. Changes only on frame_start so a video frame
// always shows a single sprite frame.
//   clk_i, rst_ni  : clock, async active-low reset
//   frame_start_i  : start-of-vblank pulse
//   jump_trig_i    : jump request (ignored while playing)
//   anim_frame_o   : current sheet frame
//   anim_busy_o    : animation playing
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned FRAMES     = FramesDefault,
  parameter int unsigned FRAME_HOLD = FrameHoldDefault,
  parameter int unsigned FRAME_W    = $clog2(FRAMES),
  parameter int unsigned HOLD_W     = $clog2(FRAME_HOLD)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               frame_start_i,
  input  logic               jump_trig_i,
  output logic [FRAME_W-1:0] anim_frame_o,
  output logic               anim_busy_o
);

  anim_state_t        state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hold_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    unique case (state_q)
      IDLE: begin
        // A frame_start coinciding with the trigger is deliberately not counted.
        if (jump_trig_i) begin
          state_d = PLAY;
          hold_d  = '0;
          frame_d = '0;
        end
      end
      PLAY: begin
        if (frame_start_i) begin
          if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
            hold_d = '0;
            if (frame_q == FRAME_W'(FRAMES - 1)) begin
              state_d = IDLE;
              frame_d = '0;
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign anim_frame_o = frame_q;
  assign anim_busy_o  = (state_q == PLAY);

endmodule

// File: rtl/batman_sprite_fetch.sv
// Pixel source for the character palette lookup. Latches the sprite position
// at frame_start, maps the VGA draw coordinate into the current sheet frame,
// issues a registered sprite-ROM address and returns the palette index plus
// an opaque flag two cycles after the draw coordinate.
//   Clk, Reset_n          : pixel clock, async active-low reset
//   frame_start           : start-of-vblank pulse (latches spr_x/spr_y)
//   jump_trig             : jump animation request
//   spr_x, spr_y          : sprite top-left on screen
//   draw_x, draw_y        : current VGA pixel
//   rom_addr / rom_data   : sprite ROM port, data one cycle after address
//   pix_index, pix_opaque : palette index and drawn flag
//   anim_busy, anim_frame : animation status
module batman_sprite_fetch
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W      = SprWDefault,
  parameter int unsigned SPR_H      = SprHDefault,
  parameter int unsigned FRAMES     = FramesDefault,
  parameter int unsigned FRAME_HOLD = FrameHoldDefault,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned FRAME_W    = $clog2(FRAMES)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic               jump_trig,
  input  logic [9:0]         spr_x,
  input  logic [9:0]         spr_y,
  input  logic [9:0]         draw_x,
  input  logic [9:0]         draw_y,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [3:0]         rom_data,
  output logic [3:0]         pix_index,
  output logic               pix_opaque,
  output logic               anim_busy,
  output logic [FRAME_W-1:0] anim_frame
);

  localparam logic [10:0] SprW11 = 11'(SPR_W);
  localparam logic [10:0] SprH11 = 11'(SPR_H);

  sprite_anim_ctrl #(
    .FRAMES    (FRAMES),
    .FRAME_HOLD(FRAME_HOLD),
    .FRAME_W   (FRAME_W)
  ) u_anim (
    .clk_i        (Clk),
    .rst_ni       (Reset_n),
    .frame_start_i(frame_start),
    .jump_trig_i  (jump_trig),
    .anim_frame_o (anim_frame),
    .anim_busy_o  (anim_busy)
  );

  // Position latch: mid-frame moves take effect at the next frame_start.
  logic [9:0] pos_x_q, pos_y_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
    end else if (frame_start) begin
      pos_x_q <= spr_x;
      pos_y_q <= spr_y;
    end
  end

  // S0: sprite-relative coordinate; bit 10 set means left of / above the box.
  logic [10:0]       rel_x, rel_y;
  logic              in_box;
  logic [ADDR_W-1:0] rom_addr_d;

  always_comb begin
    rel_x  = {1'b0, draw_x} - {1'b0, pos_x_q};
    rel_y  = {1'b0, draw_y} - {1'b0, pos_y_q};
    in_box = !rel_x[10] && (rel_x < SprW11) && !rel_y[10] && (rel_y < SprH11);
    rom_addr_d = '0;
    if (in_box) begin
      rom_addr_d = ADDR_W'(anim_frame) * ADDR_W'(SPR_W * SPR_H)
                 + ADDR_W'(rel_y) * ADDR_W'(SPR_W) + ADDR_W'(rel_x);
    end
  end

  // S1: ROM address and box flag; S2: palette result once rom_data returns.
  logic [ADDR_W-1:0] rom_addr_q;
  logic              in_box_q;
  logic [3:0]        pix_index_q, pix_index_d;
  logic              pix_opaque_q, pix_opaque_d;

  always_comb begin
    pix_index_d  = in_box_q ? rom_data : TRANSPARENT_IDX;
    pix_opaque_d = in_box_q && (rom_data != TRANSPARENT_IDX);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q   <= '0;
      in_box_q     <= 1'b0;
      pix_index_q  <= '0;
      pix_opaque_q <= 1'b0;
    end else begin
      rom_addr_q   <= rom_addr_d;
      in_box_q     <= in_box;
      pix_index_q  <= pix_index_d;
      pix_opaque_q <= pix_opaque_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign pix_index  = pix_index_q;
  assign pix_opaque = pix_opaque_q;

endmodule

// File: tb/tb_batman_sprite_fetch.sv
// Directed bench for batman_sprite_fetch. Pixel requests push their expected
// ROM address and palette result into queues; a monitor pops and compares
// them when the corresponding pipeline stage is presented.
module tb_batman_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start, jump_trig;
  logic [9:0]  spr_x, spr_y, draw_x, draw_y;
  logic [13:0] rom_addr;
  logic [3:0]  rom_data, pix_index;
  logic        pix_opaque, anim_busy;
  logic [1:0]  anim_frame;

  int n_checks = 0;
  int n_fail   = 0;

  logic [13:0] addr_q[$];
  logic [4:0]  pix_q[$];   // {opaque, index}
  logic        issue = 1'b0;
  logic        v1 = 1'b0, v2 = 1'b0;

  always #5 Clk = ~Clk;

  batman_sprite_fetch dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_start(frame_start),
    .jump_trig  (jump_trig),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_index  (pix_index),
    .pix_opaque (pix_opaque),
    .anim_busy  (anim_busy),
    .anim_frame (anim_frame)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: track which cycles carry a bench-issued request.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v1 = 1'b0;
      v2 = 1'b0;
    end else begin
      v2 = v1;
      v1 = issue;
    end
  end

  always @(negedge Clk) begin
    logic [13:0] ea;
    logic [4:0]  ep;
    if (v1) begin
      if (addr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rom_addr: got %0d, expected nothing queued", rom_addr);
      end else begin
        ea = addr_q.pop_front();
        chk("rom_addr", rom_addr, ea);
      end
    end
    if (v2) begin
      if (pix_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pix: got %0d, expected nothing queued", {pix_opaque, pix_index});
      end else begin
        ep = pix_q.pop_front();
        chk("pix {opaque,index}", {pix_opaque, pix_index}, ep);
      end
    end
  end

  task automatic pix(input logic [9:0] dx, input logic [9:0] dy, input logic [13:0] e_addr,
                     input logic [3:0] rdata, input logic [3:0] e_idx, input logic e_opq);
    @(negedge Clk);
    draw_x = dx;
    draw_y = dy;
    issue  = 1'b1;
    addr_q.push_back(e_addr);
    pix_q.push_back({e_opq, e_idx});
    @(negedge Clk);
    issue    = 1'b0;
    rom_data = rdata;
    @(negedge Clk);
  endtask

  task automatic fs_pulse();
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic jt_pulse();
    @(negedge Clk);
    jump_trig = 1'b1;
    @(negedge Clk);
    jump_trig = 1'b0;
  endtask

  task automatic chk_anim(input string name, input logic e_busy, input logic [1:0] e_frame);
    chk({name, " anim_busy"}, anim_busy, e_busy);
    chk({name, " anim_frame"}, anim_frame, e_frame);
  endtask

  task automatic play_24(input string name, input bit retrig);
    for (int k = 1; k <= 24; k++) begin
      if (retrig && k == 10) jt_pulse();
      fs_pulse();
      chk_anim(name, (k < 24), (k < 24) ? 2'(k / 6) : 2'd0);
      if (!retrig && k == 12) pix(10'd110, 10'd205, 14'd8522, 4'd2, 4'd2, 1'b1);
    end
  endtask

  initial begin
    Reset_n     = 1'b0;
    frame_start = 1'b0;
    jump_trig   = 1'b0;
    spr_x       = '0;
    spr_y       = '0;
    draw_x      = '0;
    draw_y      = '0;
    rom_data    = '0;

    #1;
    chk("reset rom_addr", rom_addr, 0);
    chk("reset pix_index", pix_index, 0);
    chk("reset pix_opaque", pix_opaque, 0);
    chk_anim("reset", 1'b0, 2'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Basic in-box fetch and box boundaries.
    spr_x = 10'd100;
    spr_y = 10'd200;
    fs_pulse();
    pix(10'd110, 10'd205, 14'd330, 4'd7, 4'd7, 1'b1);
    pix(10'd99,  10'd205, 14'd0,    4'd7, 4'd0, 1'b0);
    pix(10'd164, 10'd205, 14'd0,    4'd5, 4'd0, 1'b0);
    pix(10'd110, 10'd199, 14'd0,    4'd5, 4'd0, 1'b0);
    pix(10'd163, 10'd263, 14'd4095, 4'd9, 4'd9, 1'b1);
    pix(10'd100, 10'd200, 14'd0,    4'd3, 4'd3, 1'b1);
    pix(10'd110, 10'd264, 14'd0,    4'd3, 4'd0, 1'b0);
    chk_anim("idle", 1'b0, 2'd0);

    // Full jump sequence, with a fetch during frame 2.
    jt_pulse();
    chk_anim("jump start", 1'b1, 2'd0);
    play_24("jump", 1'b0);

    // Trigger coinciding with frame_start; retrigger mid-play is ignored.
    @(negedge Clk);
    jump_trig   = 1'b1;
    frame_start = 1'b1;
    @(negedge Clk);
    jump_trig   = 1'b0;
    frame_start = 1'b0;
    chk_anim("trig+fs start", 1'b1, 2'd0);
    play_24("trig+fs", 1'b1);

    // Mid-frame position change waits for frame_start.
    @(negedge Clk);
    spr_x = 10'd300;
    pix(10'd110, 10'd205, 14'd330, 4'd7, 4'd7, 1'b1);
    pix(10'd310, 10'd205, 14'd0,   4'd7, 4'd0, 1'b0);
    fs_pulse();
    pix(10'd310, 10'd205, 14'd330, 4'd0, 4'd0, 1'b0);
    pix(10'd110, 10'd205, 14'd0,   4'd7, 4'd0, 1'b0);

    // Asynchronous reset while playing frame 2.
    spr_x = 10'd100;
    fs_pulse();
    jt_pulse();
    for (int k = 1; k <= 12; k++) fs_pulse();
    chk_anim("pre-reset", 1'b1, 2'd2);
    pix(10'd110, 10'd205, 14'd8522, 4'd7, 4'd7, 1'b1);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("async reset rom_addr", rom_addr, 0);
    chk("async reset pix_index", pix_index, 0);
    chk("async reset pix_opaque", pix_opaque, 0);
    chk_anim("async reset", 1'b0, 2'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    chk_anim("after reset", 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/batman_sprite_fetch.md
Name: batman_sprite_fetch

Overview:
Pixel-source stage feeding the character palette lookup. It maps the VGA draw coordinate onto the Batman jump sprite sheet and issues the sprite-ROM address. It returns the 4-bit palette index plus an opaque flag to the colour mux. It also owns the jump animation sequencer, which selects the sheet frame and advances only on frame boundaries so the sprite never tears.

Parameters:
SPR_W, 64, sprite width in pixels (power of two)
SPR_H, 64, sprite height in pixels
FRAMES, 4, animation frames in sheet, stored consecutively
FRAME_HOLD, 6, frame_start pulses each animation frame is shown
ADDR_W, 14, ROM address width = clog2(FRAMES*SPR_W*SPR_H)

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
jump_trig  in  1  request jump animation (level or pulse)
spr_x  in  10  sprite top-left X (screen)
spr_y  in  10  sprite top-left Y (screen)
draw_x  in  10  current VGA pixel X
draw_y  in  10  current VGA pixel Y
rom_addr  out  ADDR_W  sprite ROM address (registered)
rom_data  in  4  ROM palette index, valid 1 cycle after rom_addr
pix_index  out  4  palette index for the palette stage
pix_opaque  out  1  1 = sprite pixel drawn, 0 = background shows
anim_busy  out  1  jump animation playing
anim_frame  out  2  current displayed frame (clog2(FRAMES))

Behaviour:
- Reset (async, Reset_n=0): all outputs 0; state IDLE; hold counter 0; latched position (0,0); pipeline flags cleared.
- Position latch: spr_x/spr_y are captured only on frame_start. Mid-frame changes have no effect until the next frame_start.
- Animation FSM, states IDLE and PLAY:
  - IDLE + jump_trig -> PLAY, frame=0, hold=0. A frame_start in the same cycle is not counted.
  - PLAY + frame_start: if hold==FRAME_HOLD-1, then hold=0 and frame advances. Otherwise hold++.
  - When frame would advance past FRAMES-1: -> IDLE, frame=0.
  - jump_trig is ignored in PLAY. A trigger held through the return to IDLE restarts on the next cycle.
  - anim_busy = (state==PLAY). Total play time is FRAMES*FRAME_HOLD frame_starts.
- Fetch pipeline, fixed latency 2 cycles from draw_x/draw_y to pix_index/pix_opaque:
  - S0 (combinational): rel_x = draw_x - pos_x, rel_y = draw_y - pos_y, both 11-bit signed. in_box = rel_x in [0,SPR_W) and rel_y in [0,SPR_H).
  - S1 (register): rom_addr = anim_frame*SPR_W*SPR_H + rel_y*SPR_W + rel_x when in_box, else 0. in_box_d1 is registered alongside.
  - S2 (register): pix_index = in_box_d2 ? rom_data : 0. pix_opaque = in_box_d2 && (rom_data != 0).
- Index 0 is the transparent key colour; it is never reported opaque.
- Arithmetic: address math is unsigned at ADDR_W bits. No overflow is possible for in_box pixels.
- Screen-edge coordinates wrap-free: negative rel_* means out of box.
- anim_frame changes only on frame_start, so one video frame uses one sprite frame.

Decomposition:
- Package sprite_pkg holds:
  - SPR_W, SPR_H, FRAMES, FRAME_HOLD defaults.
  - The anim_state_t enum {IDLE, PLAY}.
  - The TRANSPARENT_IDX=4'h0 constant.
- Sub-module sprite_anim_ctrl: FSM, hold counter and frame register (inputs frame_start, jump_trig; outputs anim_frame, anim_busy).
- The top module contains the position latch and the fetch pipeline.

Test Plan:
1. Reset, spr=(100,200), one frame_start, draw=(110,205) -> rom_addr=330 after 1 cycle. Drive rom_data=7 -> pix_index=7, pix_opaque=1 at cycle 2.
2. Same setup, draw=(99,205) and draw=(164,205) -> rom_addr=0, pix_index=0, pix_opaque=0. Corner draw=(163,263) -> rom_addr=4095.
3. jump_trig pulse, then 24 frame_starts -> anim_frame 0,1,2,3, each held for 6 pulses. anim_busy=1 throughout, then 0 after the 24th. During frame 2, draw=(110,205) -> rom_addr=8522.
4. jump_trig asserted with frame_start in the same cycle from IDLE -> PLAY, hold=0. A second jump_trig mid-PLAY -> sequence unchanged (still 24 pulses total).
5. Change spr_x to 300 mid-frame -> addresses still use 100 until the next frame_start, then use 300. rom_data=0 in box -> pix_opaque=0.
6. Assert Reset_n=0 mid-PLAY at frame 2 -> immediately anim_busy=0, anim_frame=0, pix_index=0, rom_addr=0, without waiting for a clock edge.
